// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, blanking constants and digit-index type
// for the multiplexed common-anode 7-segment driver.
package seg7_pkg;

    // Digit index: 0 is the rightmost digit
    typedef logic [1:0] dig_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed hex display driver with tear-free frame
// reloads, per-slot dead time and optional leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 16,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic        i_sysclk,
    input  logic        i_sysrst,
    input  logic [15:0] i_data,
    input  logic        i_data_vld,
    input  logic [3:0]  i_dp,
    input  logic        i_blank,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic [3:0]  o_an,
    output logic        o_frame
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    dig_t          dig_q, dig_d;
    logic [15:0]   shadow_q, shadow_d, disp_q, disp_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          frame_q, frame_d;

    logic          slot_end, frame_end, dark;
    logic [3:0]    nib, lz;
    logic [6:0]    dec_seg;

    seg7_hex_dec u_dec (
        .hex_i (nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        slot_end  = div_q == DW'(SCAN_DIV - 1);
        frame_end = slot_end && (dig_q == 2'd3);
        div_d     = slot_end ? '0 : div_q + 1'b1;
        dig_d     = slot_end ? dig_q + 2'd1 : dig_q;
        shadow_d  = i_data_vld ? i_data : shadow_q;
        // shadow_d already carries a same-cycle capture, giving the bypass for free
        disp_d    = frame_end ? shadow_d : disp_q;
        nib       = disp_q[{dig_q, 2'b00} +: 4];
        lz[3]     = disp_q[15:12] == 4'h0;
        lz[2]     = lz[3] && (disp_q[11:8] == 4'h0);
        lz[1]     = lz[2] && (disp_q[7:4] == 4'h0);
        lz[0]     = 1'b0;
        dark      = (div_q == '0) || (BLANK_LZ && lz[dig_q]);
        an_d      = (dark || i_blank) ? AN_OFF : ~(4'b0001 << dig_q);
        seg_d     = dark ? SEG_OFF : dec_seg;
        dp_d      = dark || !i_dp[dig_q];
        frame_d   = frame_end;
    end

    always_ff @(posedge i_sysclk or negedge i_sysrst) begin
        if (!i_sysrst) begin
            div_q    <= '0;
            dig_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            an_q     <= AN_OFF;
            frame_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            dig_q    <= dig_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: checks two seg7_scan instances (plain and leading-zero blanking)
// against a cycle-position model plus literal per-frame expectations.
module tb_seg7_scan;

    localparam int D = 4;
    localparam logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [15:0] AN_D0  = {4'b1111, 4'b1111, 4'b1111, 4'b1110};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic        vld, blank;
    logic [3:0]  dp;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, frame0, frame1;
    logic [3:0]  an0, an1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg7_scan #(.SCAN_DIV(D), .BLANK_LZ(1'b0)) u_dut0 (
        .i_sysclk(clk), .i_sysrst(rst_n), .i_data(data), .i_data_vld(vld), .i_dp(dp),
        .i_blank(blank), .o_seg(seg0), .o_dp(dp0), .o_an(an0), .o_frame(frame0)
    );

    seg7_scan #(.SCAN_DIV(D), .BLANK_LZ(1'b1)) u_dut1 (
        .i_sysclk(clk), .i_sysrst(rst_n), .i_data(data), .i_data_vld(vld), .i_dp(dp),
        .i_blank(blank), .o_seg(seg1), .o_dp(dp1), .o_an(an1), .o_frame(frame1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: position c in the frame (0..4D-1) fixes slot phase and digit
    function automatic bit m_dark(int c, logic [15:0] v, bit lz);
        int d = (c / D) % 4;
        return (c % D == 0) || (lz && d != 0 && (v >> (4 * d)) == 16'd0);
    endfunction

    function automatic logic [3:0] m_an(int c, logic [15:0] v, bit lz, logic blk);
        return (m_dark(c, v, lz) || blk) ? 4'hF : ~(4'b0001 << ((c / D) % 4));
    endfunction

    function automatic logic [6:0] m_seg(int c, logic [15:0] v, bit lz);
        return m_dark(c, v, lz) ? 7'h7F : SEGTAB[4'(v >> (4 * ((c / D) % 4)))];
    endfunction

    function automatic logic m_dp(int c, logic [15:0] v, bit lz, logic [3:0] p);
        return m_dark(c, v, lz) ? 1'b1 : ~p[(c / D) % 4];
    endfunction

    int          m_c;
    logic [15:0] m_shadow, m_shown;
    logic [3:0]  e_an0, e_an1;
    logic [6:0]  e_seg0, e_seg1;
    logic        e_dp0, e_dp1, e_frame;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_c <= 0; m_shadow <= '0; m_shown <= '0;
            e_an0 <= 4'hF; e_an1 <= 4'hF; e_seg0 <= 7'h7F; e_seg1 <= 7'h7F;
            e_dp0 <= 1'b1; e_dp1 <= 1'b1; e_frame <= 1'b0;
        end else begin
            e_an0   <= m_an(m_c, m_shown, 1'b0, blank);
            e_an1   <= m_an(m_c, m_shown, 1'b1, blank);
            e_seg0  <= m_seg(m_c, m_shown, 1'b0);
            e_seg1  <= m_seg(m_c, m_shown, 1'b1);
            e_dp0   <= m_dp(m_c, m_shown, 1'b0, dp);
            e_dp1   <= m_dp(m_c, m_shown, 1'b1, dp);
            e_frame <= m_c == 4 * D - 1;
            m_shadow <= vld ? data : m_shadow;
            if (m_c == 4 * D - 1) m_shown <= vld ? data : m_shadow;
            m_c <= (m_c + 1) % (4 * D);
        end
    end

    always @(negedge clk) begin
        chk("m_an0", an0, e_an0);
        chk("m_seg0", seg0, e_seg0);
        chk("m_dp0", dp0, e_dp0);
        chk("m_frame0", frame0, e_frame);
        chk("m_an1", an1, e_an1);
        chk("m_seg1", seg1, e_seg1);
        chk("m_dp1", dp1, e_dp1);
        chk("m_frame1", frame1, e_frame);
    end

    task automatic wait_frame();
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = frame0;
        end
        chk("frame_timeout", found, 1'b1);
    endtask

    // Starts on a frame-pulse cycle and ends on the next one; byp drives bv
    // with valid so it lands on the closing frame-end edge.
    task automatic frame_lit(input bit lz, input logic [15:0] an4, input logic [27:0] seg4,
                             input logic [3:0] dpe, input bit byp, input logic [15:0] bv);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lit_dead_an", lz ? an1 : an0, 4'hF);
            chk("lit_dead_seg", lz ? seg1 : seg0, 7'h7F);
            chk("lit_dead_dp", lz ? dp1 : dp0, 1'b1);
            for (int j = 0; j < 3; j++) begin
                if (k == 3 && j == 2 && byp) begin data = bv; vld = 1'b1; end
                @(negedge clk);
                chk("lit_an", lz ? an1 : an0, an4[4*k +: 4]);
                chk("lit_seg", lz ? seg1 : seg0, seg4[7*k +: 7]);
                chk("lit_dp", lz ? dp1 : dp0, dpe[k]);
            end
        end
        vld = 1'b0;
        chk("lit_frame", lz ? frame1 : frame0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; data = '0; vld = 1'b0; dp = '0; blank = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_an", an0, 4'hF);
        chk("rst_seg", seg0, 7'h7F);
        chk("rst_dp", dp0, 1'b1);
        chk("rst_frame", frame0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_dead", an0, 4'hF);
        repeat (3) begin
            @(negedge clk);
            chk("first_an", an0, 4'b1110);
            chk("first_seg", seg0, 7'h40);
            chk("first_lz_an", an1, 4'b1110);
        end
        data = 16'h12AF; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        wait_frame();
        frame_lit(1'b0, AN_ALL, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 1'b0, 16'h0);
        @(negedge clk);
        data = 16'h0000; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        wait_frame();
        fork
            frame_lit(1'b0, AN_ALL, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0, 16'h0);
            begin
                repeat (5) @(negedge clk);
                data = 16'hFFF0; vld = 1'b1;
                @(negedge clk);
                vld = 1'b0;
            end
        join
        frame_lit(1'b0, AN_ALL, {7'h0E, 7'h0E, 7'h0E, 7'h40}, 4'hF, 1'b1, 16'h5555);
        frame_lit(1'b0, AN_ALL, {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF, 1'b1, 16'h000F);
        frame_lit(1'b1, AN_D0, {7'h7F, 7'h7F, 7'h7F, 7'h0E}, 4'hF, 1'b1, 16'h0000);
        frame_lit(1'b1, AN_D0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 1'b0, 16'h0);
        dp = 4'b0100;
        frame_lit(1'b0, AN_ALL, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1011, 1'b0, 16'h0);
        dp = 4'b0000;
        repeat (2) @(negedge clk);
        blank = 1'b1;
        @(negedge clk);
        chk("blank_an0", an0, 4'hF);
        chk("blank_an1", an1, 4'hF);
        wait_frame();
        blank = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", an0, 4'hF);
        chk("arst_seg", seg0, 7'h7F);
        chk("arst_dp", dp0, 1'b1);
        chk("arst_frame", frame0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
